// File: rtl/fsm_din_gen.sv
// fsm_din_gen: serial din stimulus generator for the idle/s0/s1 pulse FSM, with phase mirror and predicted dout
module fsm_din_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_pulses,
  input  logic [GAP_W-1:0] req_gap,
  input  logic             abort,
  output logic             din_out,
  output logic             exp_dout,
  output logic             phase,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] rem_cnt, rem_n;
  logic [GAP_W-1:0] gap_ld, gap_ld_n, gap_cnt, gap_n;
  logic phase_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem_cnt <= '0;
      gap_ld  <= '0;
      gap_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      state   <= state_n;
      rem_cnt <= rem_n;
      gap_ld  <= gap_ld_n;
      gap_cnt <= gap_n;
      phase   <= phase_n;
    end
  end
  always_comb begin
    state_n  = state;
    rem_n    = rem_cnt;
    gap_ld_n = gap_ld;
    gap_n    = gap_cnt;
    phase_n  = phase;
    case (state)
      IDLE: if (req_valid) begin
        rem_n    = req_pulses;
        gap_ld_n = req_gap;
        state_n  = (req_pulses == '0) ? DONE : HIGH;
      end
      HIGH: begin
        phase_n = ~phase;
        rem_n   = phase ? rem_cnt - 1'b1 : rem_cnt;
        gap_n   = gap_ld;
        state_n = abort ? IDLE : (rem_n == '0) ? DONE : (gap_ld == '0) ? HIGH : GAP;
      end
      GAP: begin
        gap_n   = gap_cnt - 1'b1;
        state_n = abort ? IDLE : (gap_cnt == GAP_W'(1)) ? HIGH : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  assign req_ready = (state == IDLE);
  assign din_out   = (state == HIGH);
  assign exp_dout  = din_out & phase;
  assign busy      = (state == HIGH) || (state == GAP);
  assign done      = (state == DONE);
endmodule

// File: tb/tb_fsm_din_gen.sv
// tb_fsm_din_gen: directed checks of fsm_din_gen plus co-simulation against a behavioural pulse FSM
module tb_fsm_din_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_pulses = '0;
  logic [3:0] req_gap = '0;
  logic       abort = 1'b0;
  logic       din_out, exp_dout, phase, busy, done;
  logic       fsm_s1;
  int         tests = 0;
  int         fails = 0;

  fsm_din_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pulses(req_pulses), .req_gap(req_gap), .abort(abort),
    .din_out(din_out), .exp_dout(exp_dout), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) fsm_s1 <= 1'b0;
    else if (din_out) fsm_s1 <= ~fsm_s1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_din"}, din_out, 0);
    chk({tag, "_exp"}, exp_dout, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic request(input logic [7:0] n, input logic [3:0] g);
    req_pulses = n;
    req_gap    = g;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic cosim(input int n, input int g);
    int mism = 0;
    int pulses = 0;
    int cyc = 0;
    bit seen = 0;
    request(8'(n), 4'(g));
    while (!seen && cyc < 10000) begin
      if (exp_dout !== (din_out & fsm_s1)) mism++;
      if (din_out & fsm_s1) pulses++;
      if (done) seen = 1;
      else begin
        step();
        cyc++;
      end
    end
    chk($sformatf("cosim_done_n%0d_g%0d", n, g), 32'(seen), 1);
    chk($sformatf("cosim_mism_n%0d_g%0d", n, g), mism, 0);
    chk($sformatf("cosim_pulses_n%0d_g%0d", n, g), pulses, n);
    step();
  endtask

  initial begin
    logic [9:0] pat;
    #1;
    chk_reset("in_reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk_reset("after_reset");

    request(8'd1, 4'd0);
    chk("t1_c1_din", din_out, 1);
    chk("t1_c1_exp", exp_dout, 0);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ready", req_ready, 0);
    step();
    chk("t1_c2_din", din_out, 1);
    chk("t1_c2_exp", exp_dout, 1);
    step();
    chk("t1_c3_done", done, 1);
    chk("t1_c3_din", din_out, 0);
    chk("t1_c3_phase", phase, 0);
    chk("t1_c3_ready", req_ready, 0);
    step();
    chk("t1_c4_ready", req_ready, 1);
    chk("t1_c4_done", done, 0);

    pat = 10'b1001001001;
    request(8'd2, 4'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_din_%0d", i), din_out, pat[9-i]);
      chk($sformatf("t2_exp_%0d", i), exp_dout, (i == 3 || i == 9) ? 1 : 0);
      chk($sformatf("t2_done_%0d", i), done, 0);
      step();
    end
    chk("t2_done", done, 1);
    chk("t2_phase", phase, 0);
    step();

    request(8'd0, 4'd5);
    chk("t3_done", done, 1);
    chk("t3_din", din_out, 0);
    chk("t3_ready_in_done", req_ready, 0);
    step();
    chk("t3_ready", req_ready, 1);
    chk("t3_done_clear", done, 0);

    request(8'd3, 4'd1);
    chk("t4_h1", din_out, 1);
    step();
    chk("t4_g1", din_out, 0);
    step();
    chk("t4_h2_exp", exp_dout, 1);
    step();
    chk("t4_g2", busy, 1);
    step();
    chk("t4_h3_din", din_out, 1);
    chk("t4_h3_exp", exp_dout, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_ready", req_ready, 1);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_phase", phase, 1);
    request(8'd1, 4'd0);
    chk("t4_new_din", din_out, 1);
    chk("t4_new_exp", exp_dout, 1);
    step();
    chk("t4_new_done", done, 1);
    chk("t4_new_phase", phase, 0);
    step();

    request(8'd2, 4'd3);
    step();
    chk("t5_gap_busy", busy, 1);
    chk("t5_gap_phase", phase, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset("t5_async");
    #1 rst = 1'b0;
    step();
    step();
    chk_reset("t5_release");

    cosim(1, 0);
    cosim(5, 3);
    cosim(0, 7);
    cosim(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    cosim(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    cosim(255, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
